// File: rtl/tri_dac_spi_tx_if.sv
// Signal bundle between the triangle generator side and the DAC SPI transmitter.
// Latency: none, wires only.
// Backpressure: none; the transmitter snapshots inputs once per frame and never stalls the source.
// Ports: en, tri_pos_bus, tri_neg_bus, ovr_clr (into the transmitter);
//        dac_cs_n, dac_sclk, dac_mosi, dac_ldac_n, busy, frame_done, overrun (out of it).
interface tri_dac_spi_tx_if;
    logic         en;
    logic [255:0] tri_pos_bus;
    logic [255:0] tri_neg_bus;
    logic         ovr_clr;
    logic         dac_cs_n;
    logic         dac_sclk;
    logic         dac_mosi;
    logic         dac_ldac_n;
    logic         busy;
    logic         frame_done;
    logic         overrun;

    modport master (
        output en, tri_pos_bus, tri_neg_bus, ovr_clr,
        input  dac_cs_n, dac_sclk, dac_mosi, dac_ldac_n, busy, frame_done, overrun
    );

    modport slave (
        input  en, tri_pos_bus, tri_neg_bus, ovr_clr,
        output dac_cs_n, dac_sclk, dac_mosi, dac_ldac_n, busy, frame_done, overrun
    );
endinterface

// File: rtl/tri_dac_spi_tx.sv
// Snapshots 32 triangle channel words per frame tick and writes them to a DAC over SPI, then pulses LDAC.
// Latency: cs_n falls 2 cycles after the tick cycle; frame = 32*(48*SCLK_DIV+CS_HIGH)+LDAC_CYCLES cycles.
// Backpressure: none; a tick that lands while busy is dropped and recorded in the sticky overrun flag.
// Ports: clk, rst_n (async active-low); bus (slave modport of tri_dac_spi_tx_if) carrying en,
//        tri_pos_bus, tri_neg_bus, ovr_clr in and dac_cs_n, dac_sclk, dac_mosi, dac_ldac_n,
//        busy, frame_done, overrun out.
// Optional macro TRI_DAC_OFFSET_BINARY_EN: invert data bit 15 of every word (offset-binary DACs).
module tri_dac_spi_tx #(
    parameter int FRAME_DIV   = 5000,
    parameter int SCLK_DIV    = 2,
    parameter int CS_HIGH     = 4,
    parameter int LDAC_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    tri_dac_spi_tx_if.slave   bus
);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, CS_GAP, LDAC} state_t;

    localparam int          FCW        = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAME_DIV - 1);
    localparam logic [15:0] SCLK_LAST  = 16'(SCLK_DIV - 1);
    localparam logic [15:0] GAP_LAST   = 16'(CS_HIGH - 1);
    localparam logic [15:0] LDAC_LAST  = 16'(LDAC_CYCLES - 1);

    // Header is {3'b001, channel}; the data field optionally has its sign bit flipped.
    function automatic logic [23:0] make_word(input logic [4:0] c, input logic [15:0] d);
`ifdef TRI_DAC_OFFSET_BINARY_EN
        return {3'b001, c, ~d[15], d[14:0]};
`else
        return {3'b001, c, d};
`endif
    endfunction

    state_t         state, state_nx;
    logic [FCW-1:0] fcnt;
    logic           tick;
    logic [4:0]     ch, ch_nx, ch_inc;
    logic [15:0]    step, step_nx;
    logic [4:0]     bitn, bitn_nx;
    logic [23:0]    sreg, sreg_nx;
    logic [511:0]   shadow, shadow_nx;
    logic           cs_n, cs_nx;
    logic           sclk, sclk_nx;
    logic           ldac_n, ldac_nx;
    logic           busy, busy_nx;
    logic           done_arm, arm_nx;
    logic           frame_done, done_nx;
    logic           overrun, ovr_nx;

    // Free-running frame divider, independent of en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt <= '0;
        end else if (fcnt == FRAME_LAST) begin
            fcnt <= '0;
        end else begin
            fcnt <= fcnt + 1'b1;
        end
    end

    assign tick   = (fcnt == FRAME_LAST);
    assign ch_inc = ch + 5'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ch         <= '0;
            step       <= '0;
            bitn       <= '0;
            sreg       <= '0;
            shadow     <= '0;
            cs_n       <= 1'b1;
            sclk       <= 1'b0;
            ldac_n     <= 1'b1;
            busy       <= 1'b0;
            done_arm   <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nx;
            ch         <= ch_nx;
            step       <= step_nx;
            bitn       <= bitn_nx;
            sreg       <= sreg_nx;
            shadow     <= shadow_nx;
            cs_n       <= cs_nx;
            sclk       <= sclk_nx;
            ldac_n     <= ldac_nx;
            busy       <= busy_nx;
            done_arm   <= arm_nx;
            frame_done <= done_nx;
            overrun    <= ovr_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        ch_nx     = ch;
        step_nx   = step;
        bitn_nx   = bitn;
        sreg_nx   = sreg;
        shadow_nx = shadow;
        cs_nx     = cs_n;
        sclk_nx   = sclk;
        ldac_nx   = ldac_n;
        busy_nx   = busy;
        arm_nx    = 1'b0;
        done_nx   = done_arm;
        ovr_nx    = overrun;

        // A set event in the same cycle as a clear must win.
        if (bus.ovr_clr) ovr_nx = 1'b0;
        if (tick && busy) ovr_nx = 1'b1;

        case (state)
            IDLE: begin
                if (tick && bus.en) state_nx = LOAD;
            end
            LOAD: begin
                // Word 0 is built straight from the inputs since the shadow is
                // being written on this same edge.
                shadow_nx = {bus.tri_neg_bus, bus.tri_pos_bus};
                busy_nx   = 1'b1;
                ch_nx     = '0;
                step_nx   = '0;
                bitn_nx   = '0;
                sclk_nx   = 1'b0;
                cs_nx     = 1'b0;
                sreg_nx   = make_word(5'd0, bus.tri_pos_bus[15:0]);
                state_nx  = SHIFT;
            end
            SHIFT: begin
                if (step == SCLK_LAST) begin
                    step_nx = '0;
                    sclk_nx = ~sclk;
                    if (sclk) begin
                        // Falling edge: advance data or close the word.
                        if (bitn == 5'd23) begin
                            cs_nx    = 1'b1;
                            sreg_nx  = '0;
                            bitn_nx  = '0;
                            state_nx = CS_GAP;
                        end else begin
                            bitn_nx = bitn + 5'd1;
                            sreg_nx = {sreg[22:0], 1'b0};
                        end
                    end
                end else begin
                    step_nx = step + 16'd1;
                end
            end
            CS_GAP: begin
                if (step == GAP_LAST) begin
                    step_nx = '0;
                    if (ch == 5'd31) begin
                        ldac_nx  = 1'b0;
                        state_nx = LDAC;
                    end else begin
                        // Channel k lives at shadow[16k +: 16]: pos in the low half, neg above.
                        ch_nx    = ch_inc;
                        cs_nx    = 1'b0;
                        sreg_nx  = make_word(ch_inc, shadow[{ch_inc, 4'b0000} +: 16]);
                        state_nx = SHIFT;
                    end
                end else begin
                    step_nx = step + 16'd1;
                end
            end
            LDAC: begin
                if (step == LDAC_LAST) begin
                    step_nx  = '0;
                    ldac_nx  = 1'b1;
                    busy_nx  = 1'b0;
                    arm_nx   = 1'b1;
                    state_nx = IDLE;
                end else begin
                    step_nx = step + 16'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.dac_cs_n   = cs_n;
    assign bus.dac_sclk   = sclk;
    assign bus.dac_mosi   = sreg[23];
    assign bus.dac_ldac_n = ldac_n;
    assign bus.busy       = busy;
    assign bus.frame_done = frame_done;
    assign bus.overrun    = overrun;

endmodule

// File: tb/tb_tri_dac_spi_tx.sv
module tb_tri_dac_spi_tx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tri_dac_spi_tx_if ifa ();
    tri_dac_spi_tx_if ifb ();

    tri_dac_spi_tx dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    tri_dac_spi_tx #(.FRAME_DIV(1000)) dut_short (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

`ifdef TRI_DAC_OFFSET_BINARY_EN
    localparam logic [15:0] OB = 16'h8000;
`else
    localparam logic [15:0] OB = 16'h0000;
`endif

    int nerr = 0;
    int nchk = 0;
    int cyc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // SPI monitor on dut, sampled on the falling clk edge.
    logic [23:0] wq[$];
    int          lq[$];
    int          rq[$];
    logic [23:0] msh = '0;
    int nr = 0, ll = 0, lc = 0;
    int ldac_last = 0, ldac_pulses = 0, fd_cnt = 0, fd_good = 0, viol = 0;
    logic p_cs = 1'b1, p_sclk = 1'b0, p_mosi = 1'b0, p_ldac = 1'b1, pp_ldac = 1'b1;

    always @(negedge clk) begin
        if (!ifa.dac_ldac_n && !ifa.dac_cs_n) viol++;
        if (ifa.dac_sclk !== p_sclk && ifa.dac_cs_n && p_cs) viol++;
        if (ifa.dac_sclk && p_sclk && ifa.dac_mosi !== p_mosi) viol++;
        if (!ifa.dac_cs_n) begin
            if (p_cs) begin
                msh = '0;
                nr  = 0;
                ll  = 0;
            end
            ll++;
            if (ifa.dac_sclk && !p_sclk) begin
                if (ifa.dac_mosi !== p_mosi) viol++;
                msh = {msh[22:0], ifa.dac_mosi};
                nr++;
            end
        end else if (!p_cs) begin
            wq.push_back(msh);
            lq.push_back(ll);
            rq.push_back(nr);
        end
        if (!ifa.dac_ldac_n) begin
            lc++;
        end else if (!p_ldac) begin
            ldac_last = lc;
            ldac_pulses++;
            lc = 0;
        end
        if (ifa.frame_done) begin
            fd_cnt++;
            if (p_ldac && !pp_ldac) fd_good++;
        end
        pp_ldac = p_ldac;
        p_ldac  = ifa.dac_ldac_n;
        p_cs    = ifa.dac_cs_n;
        p_sclk  = ifa.dac_sclk;
        p_mosi  = ifa.dac_mosi;
    end

    logic [15:0] exp_d [32];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic goto(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Compares a captured frame starting at queue index base against exp_d.
    task automatic check_frame(input string tag, input int base);
        int bw, bl, br;
        bw = 0; bl = 0; br = 0;
        check({tag, "_nwords"}, wq.size() - base, 32);
        if (wq.size() - base >= 32) begin
            for (int i = 0; i < 32; i++) begin
                if (wq[base+i] !== {3'b001, 5'(i), exp_d[i] ^ OB}) bw++;
                if (lq[base+i] != 96) bl++;
                if (rq[base+i] != 24) br++;
            end
        end else begin
            bw = 99;
        end
        check({tag, "_bad_words"}, bw, 0);
        check({tag, "_bad_cs_len"}, bl, 0);
        check({tag, "_bad_rises"}, br, 0);
    endtask

    int base, vb, fb, fgb, lpb;

    initial begin
        ifa.en = 1'b1;
        ifa.ovr_clr = 1'b0;
        ifa.tri_pos_bus = '0;
        ifa.tri_neg_bus = '0;
        ifa.tri_pos_bus[15:0]    = 16'h1234;
        ifa.tri_neg_bus[15:0]    = 16'hABCD;
        ifa.tri_neg_bus[255:240] = 16'h0F0F;
        ifb.en = 1'b1;
        ifb.ovr_clr = 1'b0;
        ifb.tri_pos_bus = '0;
        ifb.tri_neg_bus = '0;

        repeat (3) @(negedge clk);
        check("reset_outputs",
              {ifa.dac_cs_n, ifa.dac_sclk, ifa.dac_mosi, ifa.dac_ldac_n,
               ifa.busy, ifa.frame_done, ifa.overrun}, 7'b1001000);
        rst_n = 1'b1;

        // Short divider: frame outlasts the tick period.
        goto(1500);
        check("short_busy", ifb.busy, 1);
        check("short_ovr_after_tick1", ifb.overrun, 0);
        goto(2005);
        check("short_ovr_after_tick2", ifb.overrun, 1);
        goto(2499);
        ifb.ovr_clr = 1'b1;
        goto(2500);
        ifb.ovr_clr = 1'b0;
        check("short_ovr_cleared", ifb.overrun, 0);
        goto(2999);
        ifb.ovr_clr = 1'b1;
        goto(3000);
        ifb.ovr_clr = 1'b0;
        check("short_ovr_set_wins", ifb.overrun, 1);

        // Frame 1, with a mid-frame input change that must not leak in.
        base = wq.size(); vb = viol; fb = fd_cnt; fgb = fd_good; lpb = ldac_pulses;
        goto(5000);
        check("f1_busy_before_load", ifa.busy, 0);
        goto(5001);
        check("f1_busy_start", ifa.busy, 1);
        check("f1_cs_low_start", ifa.dac_cs_n, 0);
        goto(5600);
        ifa.tri_pos_bus[15:0]    = 16'h0000;
        ifa.tri_pos_bus[255:240] = 16'h4242;
        goto(8300);
        for (int i = 0; i < 32; i++) exp_d[i] = 16'h0000;
        exp_d[0] = 16'h1234; exp_d[16] = 16'hABCD; exp_d[31] = 16'h0F0F;
        check_frame("f1", base);
        if (wq.size() - base >= 32) begin
`ifdef TRI_DAC_OFFSET_BINARY_EN
            check("f1_word0", wq[base], 24'h209234);
            check("f1_word16", wq[base+16], 24'h302BCD);
            check("f1_word31", wq[base+31], 24'h3F8F0F);
`else
            check("f1_word0", wq[base], 24'h201234);
            check("f1_word16", wq[base+16], 24'h30ABCD);
            check("f1_word31", wq[base+31], 24'h3F0F0F);
`endif
        end else begin
            check("f1_words_present", wq.size() - base, 32);
        end
        check("f1_ldac_pulses", ldac_pulses - lpb, 1);
        check("f1_ldac_len", ldac_last, 4);
        check("f1_frame_done_cnt", fd_cnt - fb, 1);
        check("f1_frame_done_timing", fd_good - fgb, 1);
        check("f1_protocol_viol", viol - vb, 0);
        check("f1_busy_end", ifa.busy, 0);
        check("f1_overrun", ifa.overrun, 0);

        // Frame 2 carries the new values; en drops mid-frame.
        base = wq.size(); fb = fd_cnt;
        goto(10500);
        ifa.en = 1'b0;
        goto(13300);
        for (int i = 0; i < 32; i++) exp_d[i] = 16'h0000;
        exp_d[15] = 16'h4242; exp_d[16] = 16'hABCD; exp_d[31] = 16'h0F0F;
        check_frame("f2", base);
        if (wq.size() - base >= 32) begin
`ifdef TRI_DAC_OFFSET_BINARY_EN
            check("f2_word0", wq[base], 24'h208000);
            check("f2_word15", wq[base+15], 24'h2FC242);
`else
            check("f2_word0", wq[base], 24'h200000);
            check("f2_word15", wq[base+15], 24'h2F4242);
`endif
        end else begin
            check("f2_words_present", wq.size() - base, 32);
        end
        check("f2_frame_done_cnt", fd_cnt - fb, 1);

        // Tick with en low is ignored.
        base = wq.size();
        goto(15002);
        check("en_low_no_busy", ifa.busy, 0);
        goto(15500);
        check("en_low_no_words", wq.size() - base, 0);
        ifa.en = 1'b1;

        // Frame 3 interrupted by reset during word 5.
        goto(20540);
        check("f3_in_word5_cs", ifa.dac_cs_n, 0);
        check("f3_in_word5_count", wq.size() - base, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_outputs",
              {ifa.dac_cs_n, ifa.dac_sclk, ifa.dac_mosi, ifa.dac_ldac_n,
               ifa.busy, ifa.frame_done, ifa.overrun}, 7'b1001000);
        check("arst_short_overrun", ifb.overrun, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        base = wq.size();
        goto(8300);
        check_frame("f4", base);
        if (wq.size() - base >= 32) begin
`ifdef TRI_DAC_OFFSET_BINARY_EN
            check("f4_word0", wq[base], 24'h208000);
            check("f4_word5", wq[base+5], 24'h258000);
`else
            check("f4_word0", wq[base], 24'h200000);
            check("f4_word5", wq[base+5], 24'h250000);
`endif
        end else begin
            check("f4_words_present", wq.size() - base, 32);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/tri_dac_spi_tx.md
Name: tri_dac_spi_tx

Overview:
Downstream consumer of the 16-channel triangle generator. Once per frame it snapshots all 32 channel words (16 positive, 16 negative) coherently. It serialises each word as a 24-bit SPI write to an external multi-channel DAC, then pulses LDAC so all DAC outputs update together. It runs on the system clock; the frame rate comes from an internal divider.

Parameters:
FRAME_DIV, 5000, clk cycles per frame tick (10 kHz at 50 MHz); must exceed 32*(48*SCLK_DIV+CS_HIGH)+LDAC_CYCLES+4
SCLK_DIV, 2, clk cycles per SCLK half-period (≥1)
CS_HIGH, 4, clk cycles cs_n held high between words (≥1)
LDAC_CYCLES, 4, clk cycles ldac_n held low after last word (≥1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  frame enable; frame ticks are ignored while low
tri_pos_bus  in  256  channels pos0..pos15, pos k at [16k+15:16k]
tri_neg_bus  in  256  channels neg0..neg15, neg k at [16k+15:16k]
ovr_clr  in  1  clears the overrun flag
dac_cs_n  out  1  SPI chip select, active low
dac_sclk  out  1  SPI clock, idle low
dac_mosi  out  1  SPI data, MSB first
dac_ldac_n  out  1  DAC load strobe, active low
busy  out  1  high from snapshot until end of the LDAC pulse
frame_done  out  1  1-cycle pulse on the cycle after ldac_n deasserts
overrun  out  1  sticky; set when a tick arrives while busy

Behaviour:
- Reset (async, immediate, including mid-frame): cs_n=1, sclk=0, mosi=0, ldac_n=1, busy=0, frame_done=0, overrun=0, frame counter=0, FSM=IDLE.
- Frame counter: free-runs 0..FRAME_DIV-1 and wraps. tick=1 when count==FRAME_DIV-1. Runs regardless of en.
- Tick handling:
  - tick & en & IDLE → LOAD.
  - tick & busy → overrun<=1; the frame in progress is not disturbed.
  - tick & !en → no action.
- LOAD (1 cycle): latch all 512 input bits into a shadow register; busy<=1; channel index ch<=0. Inputs are not sampled again until the next LOAD.
- Channel order: ch 0..15 = pos0..pos15; ch 16..31 = neg0..neg15.
- Word format (24 bits, MSB first): {3'b001, ch[4:0], data[15:0]}.
- SHIFT:
  - cs_n<=0 and mosi<=bit23 in the same cycle.
  - sclk toggles every SCLK_DIV cycles: rising edge at +SCLK_DIV, falling edge at +2*SCLK_DIV.
  - mosi advances to the next bit on each falling edge. The DAC samples on rising edges.
  - After the 24th falling edge: cs_n<=1, mosi<=0 → CS_GAP.
  - Word period = 48*SCLK_DIV+CS_HIGH cycles.
- CS_GAP: hold cs_n high CS_HIGH cycles. If ch<31: ch<=ch+1 → SHIFT. If ch==31 → LDAC.
- LDAC: ldac_n low for LDAC_CYCLES cycles, then ldac_n<=1 and busy<=0 → IDLE. frame_done pulses the following cycle.
- en deasserted mid-frame: the current frame completes; no new frame starts.
- Overrun: ovr_clr clears it. If ovr_clr and a set event occur in the same cycle, set wins.
- Never: sclk edges while cs_n high; ldac_n low while cs_n low.

Optional Feature:
- Macro: TRI_DAC_OFFSET_BINARY_EN.
- Defined: data[15] is inverted before serialisation (two's complement → offset binary for bipolar DACs). Header bits are unchanged.
- Undefined: data is sent verbatim.

Test Plan:
- pos0=16'h1234, all other channels 0, en=1, SCLK_DIV=2 → first word after the tick is 24'h201234. cs_n is low for exactly 96 cycles. 24 sclk rising edges, each with a stable mosi bit.
- neg0=16'hABCD, neg15=16'h0F0F → word 16 = 24'h30ABCD, word 31 = 24'h3F0F0F. 32 cs_n pulses per frame, then a 4-cycle ldac_n low pulse, then a single frame_done.
- Change tri_pos_bus in the middle of a frame → every word in that frame carries the LOAD-time values. The next frame carries the new values.
- FRAME_DIV=1000 (shorter than a frame) → overrun=1 after the second tick. Pulse ovr_clr on the same cycle as a later tick → overrun stays 1.
- Assert rst_n low during word 5 → cs_n=1, sclk=0, ldac_n=1, busy=0 asynchronously. After release, the next frame starts from ch 0.
- With TRI_DAC_OFFSET_BINARY_EN defined, pos0=16'h0000 → word 0 = 24'h208000. Without the macro → 24'h200000.
